// File: rtl/dft_uart_stream_pkg.sv
// Shared types and helpers for the DFT capture-and-stream block.
package dft_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    EMIT      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Number of bytes in a captured word.
  function automatic int unsigned nbytes(input int unsigned bit_width);
    return bit_width / 8;
  endfunction

endpackage

// File: rtl/dft_uart_stream_if.sv
// Capture-side and UART-side signals of the DFT stream block.
interface dft_uart_stream_if #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [BIT_WIDTH-1:0] Data;
  logic [BIT_WIDTH-1:0] Address;
  logic [BIT_WIDTH-1:0] PC;
  logic                 RegWrite;
  logic                 enable;
  logic                 uart_busy;
  logic [7:0]           uart_dat_i;
  logic                 uart_wr_i;
  logic [LW-1:0]        fifo_level;
  logic                 overflow;

  modport master (
    output Data, Address, PC, RegWrite, enable, uart_busy,
    input  uart_dat_i, uart_wr_i, fifo_level, overflow
  );

  modport slave (
    input  Data, Address, PC, RegWrite, enable, uart_busy,
    output uart_dat_i, uart_wr_i, fifo_level, overflow
  );
endinterface

// File: rtl/dft_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module dft_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == LW'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dft_uart_stream.sv
// Captures matching register writes into a FIFO and streams each word to a UART byte by byte.
module dft_uart_stream
  import dft_uart_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH   = 32,
  parameter int unsigned          FIFO_DEPTH  = 4,
  parameter logic [BIT_WIDTH-1:0] MATCH_ADDR  = BIT_WIDTH'(32'h0000_0002),
  parameter logic [BIT_WIDTH-1:0] MATCH_PC    = BIT_WIDTH'(32'h0040_0040),
  parameter int unsigned          MSB_FIRST   = 1,
  parameter int unsigned          SYNC_EN     = 1,
  parameter logic [7:0]           SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned          ACK_TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  dft_uart_stream_if.slave bus
);
  localparam int unsigned NB = nbytes(BIT_WIDTH);
  localparam int unsigned CW = $clog2(NB + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;

  state_t               state;
  logic [BIT_WIDTH-1:0] shift_q;
  logic [CW-1:0]        bytes_left;
  logic [TW-1:0]        tmo_cnt;
  logic [7:0]           dat_q;
  logic                 wr_q;
  logic                 ovf_q;

  logic                 trig;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BIT_WIDTH-1:0] fifo_head;

  // Byte that goes out next from a word in the shift register.
  function automatic logic [7:0] head_byte(input logic [BIT_WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[BIT_WIDTH-1 -: 8];
    else                return w[7:0];
  endfunction

  // Drop the byte just sent so the following one moves into place.
  function automatic logic [BIT_WIDTH-1:0] advance(input logic [BIT_WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w << 8;
    else                return w >> 8;
  endfunction

  assign trig = bus.enable & bus.RegWrite &
                (bus.Address == MATCH_ADDR) & (bus.PC == MATCH_PC);

  dft_sync_fifo #(
    .WIDTH (BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (trig),
    .pop   (state == LOAD),
    .din   (bus.Data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.fifo_level)
  );

  // Frame sequencer; the write strobe is registered on entry to EMIT so it is high exactly while in EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bytes_left <= '0;
      tmo_cnt    <= '0;
      dat_q      <= 8'h00;
      wr_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (trig && fifo_full) ovf_q <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty && !bus.uart_busy) state <= LOAD;
        end
        LOAD: begin
          if (SYNC_EN != 0) begin
            dat_q      <= SYNC_BYTE;
            shift_q    <= fifo_head;
            bytes_left <= CW'(NB);
          end else begin
            dat_q      <= head_byte(fifo_head);
            shift_q    <= advance(fifo_head);
            bytes_left <= CW'(NB - 1);
          end
          wr_q  <= 1'b1;
          state <= EMIT;
        end
        EMIT: begin
          tmo_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.uart_busy || tmo_cnt == TW'(ACK_TIMEOUT - 1)) state <= WAIT_DONE;
          else tmo_cnt <= tmo_cnt + TW'(1);
        end
        WAIT_DONE: begin
          if (!bus.uart_busy) begin
            if (bytes_left != '0) begin
              dat_q      <= head_byte(shift_q);
              shift_q    <= advance(shift_q);
              bytes_left <= bytes_left - CW'(1);
              wr_q       <= 1'b1;
              state      <= EMIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_dat_i = dat_q;
  assign bus.uart_wr_i  = wr_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_dft_uart_stream.sv
// Self-checking bench: random captures against a word-queue reference of the byte stream.
module tb_dft_uart_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dft_uart_stream_if #(.BIT_WIDTH(32), .FIFO_DEPTH(4)) bus ();
  dft_uart_stream_if #(.BIT_WIDTH(16), .FIFO_DEPTH(4)) bus2 ();

  dft_uart_stream #(
    .BIT_WIDTH(32), .FIFO_DEPTH(4), .MATCH_ADDR(32'h2), .MATCH_PC(32'h0040_0040),
    .MSB_FIRST(1), .SYNC_EN(1), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(16)
  ) u_dut (.clk(clk), .rst(rst), .bus(bus));

  dft_uart_stream #(
    .BIT_WIDTH(16), .FIFO_DEPTH(4), .MATCH_ADDR(16'h2), .MATCH_PC(16'h0040),
    .MSB_FIRST(0), .SYNC_EN(0), .SYNC_BYTE(8'hA5), .ACK_TIMEOUT(16)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad = 0;
  int busy_mode = 0;     // 0: UART model, 1: busy held high, 2: busy tied low
  int phase = 0;
  int cyc = 0;
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  logic [7:0] got2_q[$];
  logic [7:0] exp_q[$];

  // UART model: busy rises two cycles after each write pulse and stays up for ten cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.uart_wr_i === 1'b1) begin
      got_q.push_back(bus.uart_dat_i);
      pulse_cyc.push_back(cyc);
      phase = 1;
    end else if (phase > 0) begin
      phase = (phase == 12) ? 0 : phase + 1;
    end
    case (busy_mode)
      1:       bus.uart_busy = 1'b1;
      2:       bus.uart_busy = 1'b0;
      default: bus.uart_busy = (phase >= 3);
    endcase
  end

  // Second instance sees a UART that never acknowledges.
  assign bus2.uart_busy = 1'b0;
  always @(negedge clk) if (bus2.uart_wr_i === 1'b1) got2_q.push_back(bus2.uart_dat_i);

  task automatic idle_inputs();
    bus.Data = $urandom; bus.Address = 32'h2; bus.PC = 32'h0040_0040;
    bus.RegWrite = 1'b0; bus.enable = 1'b1;
  endtask

  task automatic drive_match(input logic [31:0] d);
    bus.Data = d; bus.Address = 32'h2; bus.PC = 32'h0040_0040;
    bus.RegWrite = 1'b1; bus.enable = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: a frame is the optional sync byte followed by the word's bytes, MSB first.
  task automatic add_frame(input logic [31:0] w);
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  // Wait for the expected bytes after index base, compare them, then confirm nothing extra follows.
  task automatic check_stream(input string name, input int base);
    int budget;
    budget = 100 * exp_q.size() + 50;
    while (got_q.size() < base + exp_q.size() && budget > 0) begin
      @(negedge clk); budget--;
    end
    total++;
    if (got_q.size() < base + exp_q.size()) begin
      bad++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[base + i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, got_q[base + i], exp_q[i]);
        end
      end
    end
    repeat (60) @(negedge clk);
    total++;
    if (got_q.size() != base + exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size() - base, exp_q.size());
    end
    total++;
    if (bus.fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL %s_drained: fifo_level %0d, required 0", name, bus.fifo_level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (3) @(negedge clk);
    total++; if (bus.uart_wr_i !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b, required 0", bus.uart_wr_i); end
    total++; if (bus.uart_dat_i !== 8'h00) begin bad++; $display("FAIL reset_dat: got %02h, required 00", bus.uart_dat_i); end
    total++; if (bus.fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d, required 0", bus.fifo_level); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b, required 0", bus.overflow); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int base;
    do_reset(); busy_mode = 0; exp_q.delete(); base = got_q.size();
    @(negedge clk); drive_match(32'h1234_5678); add_frame(32'h1234_5678);
    @(negedge clk); idle_inputs();
    total++; if (bus.fifo_level !== 3'd1) begin bad++; $display("FAIL single_level: got %0d, required 1", bus.fifo_level); end
    @(negedge clk);
    total++; if (bus.uart_wr_i !== 1'b0) begin bad++; $display("FAIL single_early: wr %b, required 0", bus.uart_wr_i); end
    @(negedge clk);
    total++; if (bus.uart_wr_i !== 1'b1 || bus.uart_dat_i !== 8'hA5) begin
      bad++; $display("FAIL single_latency: wr %b dat %02h, required 1 a5", bus.uart_wr_i, bus.uart_dat_i);
    end
    check_stream("single", base);
  endtask

  task automatic test_nonmatch();
    int base;
    do_reset(); busy_mode = 0; base = got_q.size();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive_match($urandom);
      case (k)
        0: bus.PC = 32'h0040_0044;
        1: bus.RegWrite = 1'b0;
        default: bus.enable = 1'b0;
      endcase
      @(negedge clk); idle_inputs();
      repeat (20) @(negedge clk);
      total++; if (got_q.size() != base || bus.fifo_level !== 3'd0) begin
        bad++; $display("FAIL nonmatch%0d: pulses %0d level %0d, required 0 0", k, got_q.size() - base, bus.fifo_level);
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    logic [31:0] w;
    do_reset(); busy_mode = 1; exp_q.delete(); base = got_q.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); w = $urandom; drive_match(w);
      if (i < 4) add_frame(w);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    total++; if (bus.fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d, required 4", bus.fifo_level); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", bus.overflow); end
    busy_mode = 0;
    check_stream("ovf", base);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", bus.overflow); end
  endtask

  task automatic test_random();
    int base, n, left;
    logic [31:0] w;
    do_reset();
    for (int it = 0; it < 5; it++) begin
      busy_mode = 1; exp_q.delete(); base = got_q.size();
      n = $urandom_range(1, 4); left = n;
      while (left > 0) begin
        @(negedge clk); w = $urandom; drive_match(w);
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0: bus.PC = bus.PC + 32'd4;
            1: bus.Address = bus.Address ^ 32'h1;
            2: bus.RegWrite = 1'b0;
            default: bus.enable = 1'b0;
          endcase
        end else begin
          add_frame(w); left--;
        end
      end
      @(negedge clk); idle_inputs();
      @(negedge clk);
      total++; if (bus.fifo_level !== 3'(n)) begin bad++; $display("FAIL rand%0d_level: got %0d, required %0d", it, bus.fifo_level, n); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rand%0d_ovf: got %b, required 0", it, bus.overflow); end
      busy_mode = 0;
      check_stream($sformatf("rand%0d", it), base);
    end
  endtask

  task automatic test_timeout();
    int base;
    logic [31:0] w;
    do_reset(); busy_mode = 2; exp_q.delete(); base = got_q.size();
    w = $urandom;
    @(negedge clk); drive_match(w); add_frame(w);
    @(negedge clk); idle_inputs();
    check_stream("tmo", base);
    if (got_q.size() >= base + 5) begin
      for (int i = 1; i < 5; i++) begin
        total++;
        if (pulse_cyc[base + i] - pulse_cyc[base + i - 1] != 18) begin
          bad++; $display("FAIL tmo_gap%0d: got %0d cycles, required 18", i, pulse_cyc[base + i] - pulse_cyc[base + i - 1]);
        end
      end
    end
    busy_mode = 0;
  endtask

  task automatic test_width16();
    logic [15:0] w;
    int budget;
    w = 16'($urandom);
    exp_q.delete();
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'(w & 16'hFF)); exp_q.push_back(8'(w >> 8));
    @(negedge clk); bus2.Data = 16'hBEEF; bus2.RegWrite = 1'b1;
    @(negedge clk); bus2.Data = w;
    @(negedge clk); bus2.RegWrite = 1'b0;
    budget = 400;
    while (got2_q.size() < 4 && budget > 0) begin @(negedge clk); budget--; end
    repeat (60) @(negedge clk);
    total++;
    if (got2_q.size() != 4) begin
      bad++; $display("FAIL w16_count: got %0d bytes, required 4", got2_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got2_q[i] !== exp_q[i]) begin bad++; $display("FAIL w16_byte%0d: got %02h, required %02h", i, got2_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_midreset();
    int seen, budget;
    do_reset(); busy_mode = 1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); drive_match($urandom); end
    @(negedge clk); idle_inputs(); busy_mode = 0;
    seen = 0; budget = 400;
    while (seen < 2 && budget > 0) begin
      @(negedge clk); budget--;
      if (bus.uart_wr_i === 1'b1) seen++;
    end
    total++; if (seen < 2) begin bad++; $display("FAIL mid_wait: saw %0d pulses, required 2", seen); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (bus.uart_wr_i !== 1'b0 || bus.uart_dat_i !== 8'h00) begin
      bad++; $display("FAIL mid_out: wr %b dat %02h, required 0 00", bus.uart_wr_i, bus.uart_dat_i);
    end
    total++; if (bus.fifo_level !== 3'd0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL mid_state: level %0d ovf %b, required 0 0", bus.fifo_level, bus.overflow);
    end
    seen = 0;
    repeat (100) begin @(negedge clk); if (bus.uart_wr_i === 1'b1) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_quiet: saw %0d pulses, required 0", seen); end
  endtask

  initial begin
    bus2.Data = '0; bus2.Address = 16'h2; bus2.PC = 16'h0040;
    bus2.RegWrite = 1'b0; bus2.enable = 1'b1;
    test_reset();
    test_single();
    test_nonmatch();
    test_overflow();
    test_random();
    test_timeout();
    test_width16();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
